// File: rtl/bcd_nibble_deserializer_pkg.sv
// bcd_nibble_deserializer_pkg: shared buffer state encoding and BCD limit.
package bcd_nibble_deserializer_pkg;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd_err(input logic [3:0] word);
        return word > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_nibble_deserializer_shift4.sv
// nibble_shift4: 4-bit serial shifter with bit counter, frame sync and word_done pulse.
module nibble_shift4 #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sin,
    input  logic       i_sin_valid,
    input  logic       i_sync,
    output logic [3:0] o_word,
    output logic       o_word_done
);

    logic [3:0] r_shift;
    logic [1:0] r_bit_cnt;
    logic [3:0] w_shift_in;
    logic [3:0] w_sync_in;

    assign w_shift_in  = (MSB_FIRST != 0) ? {r_shift[2:0], i_sin} : {i_sin, r_shift[3:1]};
    assign w_sync_in   = (MSB_FIRST != 0) ? {3'b000, i_sin} : {i_sin, 3'b000};
    // The completed word includes the bit being sampled on this edge.
    assign o_word      = w_shift_in;
    assign o_word_done = i_sin_valid && !i_sync && (r_bit_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= 4'd0;
            r_bit_cnt <= 2'd0;
        end else if (i_sync) begin
            r_shift   <= i_sin_valid ? w_sync_in : 4'd0;
            r_bit_cnt <= i_sin_valid ? 2'd1 : 2'd0;
        end else if (i_sin_valid) begin
            r_shift   <= w_shift_in;
            r_bit_cnt <= r_bit_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/bcd_nibble_deserializer.sv
// bcd_nibble_deserializer: serial-to-parallel BCD word assembler with one-entry output buffer.
module bcd_nibble_deserializer
    import bcd_nibble_deserializer_pkg::*;
#(
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    input  logic             i_sync,
    output logic [3:0]       o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_bcd_err,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_digit_cnt
);

    buf_state_t       r_state;
    buf_state_t       w_state_nxt;
    logic [3:0]       w_word;
    logic             w_done;
    logic             w_load;
    logic             w_drop;
    logic [3:0]       r_dout;
    logic             r_bcd_err;
    logic             r_overrun;
    logic [CNT_W-1:0] r_digit_cnt;

    nibble_shift4 #(
        .MSB_FIRST(MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .i_sin      (i_sin),
        .i_sin_valid(i_sin_valid),
        .i_sync     (i_sync),
        .o_word     (w_word),
        .o_word_done(w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= BUF_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // A full buffer accepts a new word only when the old one leaves on the same edge.
    always_comb begin
        w_load      = w_done && ((r_state == BUF_EMPTY) || i_dout_ready);
        w_drop      = w_done && (r_state == BUF_FULL) && !i_dout_ready;
        w_state_nxt = w_done ? BUF_FULL : (i_dout_ready ? BUF_EMPTY : r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout      <= 4'd0;
            r_bcd_err   <= 1'b0;
            r_overrun   <= 1'b0;
            r_digit_cnt <= '0;
        end else begin
            if (w_load) begin
                r_dout      <= w_word;
                r_bcd_err   <= is_bcd_err(w_word);
                r_digit_cnt <= r_digit_cnt + CNT_W'(1);
            end
            if (w_drop) r_overrun <= 1'b1;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = (r_state == BUF_FULL);
    assign o_bcd_err    = r_bcd_err;
    assign o_overrun    = r_overrun;
    assign o_digit_cnt  = r_digit_cnt;

endmodule

// File: tb/tb_bcd_nibble_deserializer.sv
// tb_bcd_nibble_deserializer: random and directed checks of MSB- and LSB-first instances against a bit-queue model.
module tb_bcd_nibble_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sync = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] dout_m, dout_l;
    logic       valid_m, valid_l, err_m, err_l, ovr_m, ovr_l;
    logic [1:0] cnt_m;
    logic [7:0] cnt_l;

    int n_tot = 0;
    int n_bad = 0;

    int q[$];
    int mv[2], md[2], me[2], mo[2], mc[2];
    int mask[2] = '{3, 255};

    always #5 clk = ~clk;

    bcd_nibble_deserializer #(.MSB_FIRST(1), .CNT_W(2)) dut_m (
        .clk(clk), .rst(rst), .i_sin(sin), .i_sin_valid(sin_valid), .i_sync(sync),
        .o_dout(dout_m), .o_dout_valid(valid_m), .i_dout_ready(ready),
        .o_bcd_err(err_m), .o_overrun(ovr_m), .o_digit_cnt(cnt_m)
    );

    bcd_nibble_deserializer #(.MSB_FIRST(0), .CNT_W(8)) dut_l (
        .clk(clk), .rst(rst), .i_sin(sin), .i_sin_valid(sin_valid), .i_sync(sync),
        .o_dout(dout_l), .o_dout_valid(valid_l), .i_dout_ready(ready),
        .o_bcd_err(err_l), .o_overrun(ovr_l), .o_digit_cnt(cnt_l)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic sv, input logic s, input logic sy, input logic rdy);
        int w[2];
        logic done;
        done = 1'b0;
        if (r) begin
            q.delete();
            for (int k = 0; k < 2; k++) begin
                mv[k] = 0; md[k] = 0; me[k] = 0; mo[k] = 0; mc[k] = 0;
            end
            return;
        end
        if (sy) begin
            q.delete();
            if (sv) q.push_back(int'(s));
        end else if (sv) begin
            q.push_back(int'(s));
            if (q.size() == 4) begin
                done = 1'b1;
                w[0] = q[0] * 8 + q[1] * 4 + q[2] * 2 + q[3];
                w[1] = q[0] + q[1] * 2 + q[2] * 4 + q[3] * 8;
                q.delete();
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (done && (mv[k] == 0 || rdy)) begin
                mv[k] = 1;
                md[k] = w[k];
                me[k] = (w[k] > 9) ? 1 : 0;
                mc[k] = (mc[k] + 1) & mask[k];
            end else if (done) begin
                mo[k] = 1;
            end else if (rdy) begin
                mv[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("m_valid", int'(valid_m), mv[0]);
        check("m_overrun", int'(ovr_m), mo[0]);
        check("m_cnt", int'(cnt_m), mc[0]);
        check("l_valid", int'(valid_l), mv[1]);
        check("l_overrun", int'(ovr_l), mo[1]);
        check("l_cnt", int'(cnt_l), mc[1]);
        if (mv[0] != 0) begin
            check("m_dout", int'(dout_m), md[0]);
            check("m_err", int'(err_m), me[0]);
        end
        if (mv[1] != 0) begin
            check("l_dout", int'(dout_l), md[1]);
            check("l_err", int'(err_l), me[1]);
        end
    endtask

    task automatic step(input logic r, input logic sv, input logic s, input logic sy, input logic rdy);
        rst = r; sin_valid = sv; sin = s; sync = sy; ready = rdy;
        @(posedge clk);
        model_edge(r, sv, s, sy, rdy);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [3:0] bits, input logic rdy);
        for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, rdy);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_dout_m", int'(dout_m), 0);
        check("rst_err_l", int'(err_l), 0);
        // bits 0,1,1,1
        send(4'b0111, 1'b1);
        check("t1_dout_m", int'(dout_m), 7);
        check("t1_valid_m", int'(valid_m), 1);
        check("t1_cnt_m", int'(cnt_m), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_valid_drop", int'(valid_m), 0);
        // bits 1,0,1,1
        send(4'b1011, 1'b1);
        check("t2_dout_l", int'(dout_l), 13);
        check("t2_err_l", int'(err_l), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(4'b0011, 1'b0);
        send(4'b0101, 1'b0);
        check("t3_dout_m", int'(dout_m), 3);
        check("t3_ovr_m", int'(ovr_m), 1);
        check("t3_cnt_m", int'(cnt_m), 3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_valid_drop", int'(valid_m), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(4'b0010, 1'b0);
        for (int i = 3; i >= 1; i--) step(1'b0, 1'b1, i == 3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t4_dout_m", int'(dout_m), 9);
        check("t4_valid_m", int'(valid_m), 1);
        check("t4_ovr_m", int'(ovr_m), 0);
        check("t4_cnt_m", int'(cnt_m), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t5_dout_m", int'(dout_m), 9);
        check("t5_cnt_m", int'(cnt_m), 3);
        send(4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_valid_m", int'(valid_m), 0);
        check("t6_dout_m", int'(dout_m), 0);
        check("t6_cnt_l", int'(cnt_l), 0);
        for (int i = 0; i < 4; i++) send(4'(i + 1), 1'b1);
        check("t6_wrap_m", int'(cnt_m), 0);
        check("t6_cnt_l4", int'(cnt_l), 4);
        check("t6_dout_l", int'(dout_l), 2);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 19) == 0, 1'($urandom));
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
